// File: rtl/operand_builder_if.sv
// Key-input, ALU-request/result and display signals of the calculator operand builder.
// slave: the operand_builder itself. master: the environment around it (keypad, ALU, display).
interface operand_builder_if;
  logic [4:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_op_a;
  logic [15:0] o_op_b;
  logic [1:0]  o_opcode;
  logic        o_req_valid;
  logic        i_req_ready;
  logic [15:0] i_res;
  logic        i_res_err;
  logic        i_res_valid;
  logic [15:0] o_disp_value;
  logic        o_disp_err;

  modport slave (
    input  i_data, i_valid, i_req_ready, i_res, i_res_err, i_res_valid,
    output o_ready, o_op_a, o_op_b, o_opcode, o_req_valid, o_disp_value, o_disp_err
  );

  modport master (
    output i_data, i_valid, i_req_ready, i_res, i_res_err, i_res_valid,
    input  o_ready, o_op_a, o_op_b, o_opcode, o_req_valid, o_disp_value, o_disp_err
  );
endinterface

// File: rtl/operand_builder.sv
// Turns keystrokes into calculator operations: builds two decimal operands,
// latches the operator, issues one ALU request per operation and takes the
// result back as the next first operand (chained operations supported).
module operand_builder #(
  parameter int MAX_DIGITS = 4
) (
  input logic             clk,
  input logic             rst,
  operand_builder_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_OP_SET,
    ST_ENTER_B,
    ST_ISSUE,
    ST_WAIT_RES,
    ST_RESULT,
    ST_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      a_q, a_d;
  logic [15:0]      b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       opcode_q, opcode_d;
  logic             pend_vld_q, pend_vld_d;
  logic [1:0]       pend_op_q, pend_op_d;

  // Key decode
  logic        ready;
  logic        key_fire;
  logic        is_digit, is_ac, is_op, is_eq;
  logic [3:0]  digit;
  logic [15:0] digit_ext;
  logic [1:0]  key_op;

  assign ready     = !rst && (state_q != ST_ISSUE) && (state_q != ST_WAIT_RES);
  assign key_fire  = bus.i_valid && ready;
  assign is_digit  = bus.i_data < 5'd10;
  assign is_ac     = bus.i_data == 5'd16;
  assign is_op     = (bus.i_data >= 5'd17) && (bus.i_data <= 5'd20);
  assign is_eq     = bus.i_data == 5'd21;
  assign digit     = bus.i_data[3:0];
  assign digit_ext = {12'd0, digit};
  assign key_op    = 2'(bus.i_data - 5'd17);

  // Shared digit accumulator for whichever operand is being typed.
  // Leading zeros are swallowed and digits past MAX_DIGITS are dropped.
  logic [15:0] acc_in, acc_next;
  logic        acc_take;

  assign acc_in   = (state_q == ST_ENTER_B) ? b_q : a_q;
  assign acc_next = acc_in * 16'd10 + digit_ext;
  assign acc_take = !((digit == 4'd0) && (acc_in == 16'd0)) && (cnt_q < CNT_MAX);

  // Next-state and datapath update for every state
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    opcode_d   = opcode_q;
    pend_vld_d = pend_vld_q;
    pend_op_d  = pend_op_q;

    if (key_fire && is_ac) begin
      a_d        = '0;
      b_d        = '0;
      cnt_d      = '0;
      opcode_d   = '0;
      pend_vld_d = 1'b0;
      pend_op_d  = '0;
      state_d    = ST_ENTER_A;
    end else begin
      unique case (state_q)
        ST_ENTER_A: begin
          if (key_fire && is_digit && acc_take) begin
            a_d   = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
          end else if (key_fire && is_op) begin
            opcode_d = key_op;
            state_d  = ST_OP_SET;
          end
        end
        ST_OP_SET: begin
          if (key_fire && is_op) begin
            opcode_d = key_op;
          end else if (key_fire && is_digit) begin
            b_d     = digit_ext;
            cnt_d   = CNT_W'(digit != 4'd0);
            state_d = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (key_fire && is_digit && acc_take) begin
            b_d   = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
          end else if (key_fire && is_eq) begin
            pend_vld_d = 1'b0;
            state_d    = ST_ISSUE;
          end else if (key_fire && is_op) begin
            pend_vld_d = 1'b1;
            pend_op_d  = key_op;
            state_d    = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.i_req_ready) state_d = ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          if (bus.i_res_valid) begin
            if (bus.i_res_err) begin
              state_d = ST_ERROR;
            end else begin
              a_d   = bus.i_res;
              b_d   = '0;
              cnt_d = '0;
              if (pend_vld_q) begin
                opcode_d   = pend_op_q;
                pend_vld_d = 1'b0;
                pend_op_d  = '0;
                state_d    = ST_OP_SET;
              end else begin
                state_d = ST_RESULT;
              end
            end
          end
        end
        ST_RESULT: begin
          if (key_fire && is_digit) begin
            a_d     = digit_ext;
            cnt_d   = CNT_W'(digit != 4'd0);
            state_d = ST_ENTER_A;
          end else if (key_fire && is_op) begin
            opcode_d = key_op;
            state_d  = ST_OP_SET;
          end
        end
        ST_ERROR: ;
        default: state_d = ST_ENTER_A;
      endcase
    end
  end

  // State and operand registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q    <= ST_ENTER_A;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      opcode_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_op_q  <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      opcode_q   <= opcode_d;
      pend_vld_q <= pend_vld_d;
      pend_op_q  <= pend_op_d;
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_req_valid  = (state_q == ST_ISSUE);
  assign bus.o_op_a       = a_q;
  assign bus.o_op_b       = b_q;
  assign bus.o_opcode     = opcode_q;
  assign bus.o_disp_value = (state_q == ST_ENTER_B) ? b_q : a_q;
  assign bus.o_disp_err   = (state_q == ST_ERROR);

endmodule
